// File: rtl/dump_ctrl.sv
// Trace dump controller: walks all 512 capture-RAM entries from oldest to newest
// and hands each byte to a transmitter, one byte per tx_done handshake.
module dump_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_dump,
   input  logic [8:0] trace_end,
   input  logic [7:0] ram_rdata,
   input  logic       tx_done,
   output logic       ram_en,
   output logic [8:0] ram_addr,
   output logic [7:0] dump_data,
   output logic       send_dump,
   output logic       dump_finished,
   output logic       clr_capture_done
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LATCH,
      SEND,
      WAIT,
      FIN
   } state_e;

   state_e      state_q, state_d;
   logic [8:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [9:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // Loading the start address is the only place trace_end is used, so later
   // changes on it cannot disturb a dump that is already running.
   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      data_d           = data_q;
      cnt_d            = cnt_q;
      ram_en           = 1'b0;
      send_dump        = 1'b0;
      dump_finished    = 1'b0;
      clr_capture_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_dump) begin
               addr_d  = trace_end + 9'd1;
               cnt_d   = '0;
               state_d = RD;
            end
         end
         RD: begin
            ram_en  = 1'b1;
            state_d = LATCH;
         end
         LATCH: begin
            data_d  = ram_rdata;
            state_d = SEND;
         end
         SEND: begin
            send_dump = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               if (cnt_q == 10'd511) begin
                  state_d = FIN;
               end else begin
                  addr_d  = addr_q + 9'd1;
                  cnt_d   = cnt_q + 10'd1;
                  state_d = RD;
               end
            end
         end
         FIN: begin
            dump_finished    = 1'b1;
            clr_capture_done = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_addr  = addr_q;
   assign dump_data = data_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Directed bench for dump_ctrl: a RAM model with one-cycle read latency and a
// transmitter model that answers each send_dump with a tx_done after a gap.
module tb_dump_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_dump = 1'b0;
   logic [8:0] trace_end = '0;
   logic [7:0] ram_rdata = '0;
   logic       tx_done = 1'b0;
   logic       ram_en;
   logic [8:0] ram_addr;
   logic [7:0] dump_data;
   logic       send_dump;
   logic       dump_finished;
   logic       clr_capture_done;

   logic [7:0] mem [512];
   int total = 0;
   int bad = 0;
   int sendCount = 0;
   int finCount = 0;
   int clrCount = 0;

   dump_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .start_dump       (start_dump),
      .trace_end        (trace_end),
      .ram_rdata        (ram_rdata),
      .tx_done          (tx_done),
      .ram_en           (ram_en),
      .ram_addr         (ram_addr),
      .dump_data        (dump_data),
      .send_dump        (send_dump),
      .dump_finished    (dump_finished),
      .clr_capture_done (clr_capture_done)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: data appears the cycle after ram_en.
   always @(posedge clk) begin
      if (ram_en) ram_rdata <= mem[ram_addr];
   end

   always @(negedge clk) begin
      if (send_dump) sendCount++;
      if (dump_finished) finCount++;
      if (clr_capture_done) clrCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One dump; noisy injects inputs that must be ignored, abortAfter resets mid-dump.
   task automatic applyStimulus(input logic [8:0] te, input int gap, input int slowIdx,
                                input bit noisy, input int abortAfter);
      logic [8:0] a;
      logic [7:0] held;
      int extra, changes, g;
      int s0, f0, c0;
      s0 = sendCount;
      f0 = finCount;
      c0 = clrCount;
      a  = te + 9'd1;
      @(negedge clk);
      trace_end  = te;
      start_dump = 1'b1;
      @(negedge clk);
      start_dump = 1'b0;
      for (int i = 0; i < 512; i++) begin
         if (i == abortAfter) begin
            #2 rst = 1'b1;
            #1;
            checkOutput("rst_ram_en", ram_en, 0);
            checkOutput("rst_addr", ram_addr, 0);
            checkOutput("rst_data", dump_data, 0);
            checkOutput("rst_send", send_dump, 0);
            checkOutput("rst_fin", dump_finished, 0);
            checkOutput("rst_clr", clr_capture_done, 0);
            @(negedge clk);
            rst = 1'b0;
            extra = 0;
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (ram_en | send_dump | dump_finished | clr_capture_done) extra++;
            end
            checkOutput("abort_quiet", extra, 0);
            checkOutput("abort_sends", sendCount - s0, abortAfter);
            checkOutput("abort_fin", finCount - f0, 0);
            checkOutput("abort_clr", clrCount - c0, 0);
            return;
         end
         checkOutput("rd_ram_en", ram_en, 1);
         checkOutput("rd_addr", ram_addr, a);
         checkOutput("rd_send", send_dump, 0);
         @(negedge clk);
         checkOutput("latch_ram_en", ram_en, 0);
         checkOutput("latch_send", send_dump, 0);
         if (noisy && i == 3) trace_end = ~te;
         @(negedge clk);
         checkOutput("send", send_dump, 1);
         checkOutput("data", dump_data, mem[a]);
         held = dump_data;
         if (noisy && i == 5) tx_done = 1'b1;
         g = (i == slowIdx) ? 1000 : gap;
         extra = 0;
         changes = 0;
         for (int c = 0; c < g; c++) begin
            @(negedge clk);
            tx_done    = 1'b0;
            start_dump = noisy && i == 7 && c == 1;
            if (ram_en | send_dump | dump_finished) extra++;
            if (dump_data !== held) changes++;
         end
         start_dump = 1'b0;
         checkOutput("wait_quiet", extra, 0);
         checkOutput("wait_data_stable", changes, 0);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         a = a + 9'd1;
      end
      checkOutput("fin_pulse", dump_finished, 1);
      checkOutput("fin_clr", clr_capture_done, 1);
      checkOutput("fin_ram_en", ram_en, 0);
      if (noisy) start_dump = 1'b1;
      @(negedge clk);
      start_dump = 1'b0;
      checkOutput("fin_once", dump_finished, 0);
      checkOutput("clr_once", clr_capture_done, 0);
      extra = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (ram_en | send_dump) extra++;
      end
      checkOutput("idle_no_restart", extra, 0);
      checkOutput("send_count", sendCount - s0, 512);
      checkOutput("fin_count", finCount - f0, 1);
      checkOutput("clr_count", clrCount - c0, 1);
   endtask

   initial begin
      int extra;
      #1 rst = 1'b1;
      #2;
      checkOutput("reset_ram_en", ram_en, 0);
      checkOutput("reset_addr", ram_addr, 0);
      checkOutput("reset_data", dump_data, 0);
      checkOutput("reset_send", send_dump, 0);
      checkOutput("reset_fin", dump_finished, 0);
      checkOutput("reset_clr", clr_capture_done, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // tx_done while idle must not start anything
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ram_en | send_dump | dump_finished) extra++;
      end
      checkOutput("idle_tx_done", extra, 0);

      $display("[TB] basic dump");
      for (int i = 0; i < 512; i++) mem[i] = i[7:0];
      applyStimulus(9'h1FF, 5, -1, 1'b0, -1);

      $display("[TB] wrap-around dump");
      for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37) ^ 8'h5A;
      applyStimulus(9'h064, 5, -1, 1'b0, -1);

      $display("[TB] ignored inputs");
      applyStimulus(9'h0AB, 4, -1, 1'b1, -1);

      $display("[TB] reset mid-dump then fresh dump");
      applyStimulus(9'h123, 3, -1, 1'b0, 200);
      applyStimulus(9'h010, 5, -1, 1'b0, -1);

      $display("[TB] slow transmitter");
      applyStimulus(9'h1F0, 2, 2, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
